// File: rtl/freq_report_tx.sv
// freq_report_tx: sends one 6-byte UART frame (8N1) per accepted start request.
//   Frame layout: HEADER, data[31:24], data[23:16], data[15:8], data[7:0], CHK,
//   where CHK is the 8-bit wrapping sum of the four payload bytes.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - frame request, accepted only while idle
//   data  - 32-bit payload, captured on the accept cycle
//   busy  - high while a frame is in flight
//   done  - one-cycle pulse when a frame completes
//   txd   - registered UART serial output, idle high
module freq_report_tx #(
    parameter int         CLKS_PER_BIT = 10417,
    parameter logic [7:0] HEADER       = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        txd
);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    // The last stop bit ends one cycle early: its final cycle is the idle
    // cycle where done is high and busy is already low.
    localparam logic [15:0] END_LAST = 16'(CLKS_PER_BIT - 2);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [2:0]  byte_idx, byte_nxt;
    logic [31:0] data_q;
    logic [7:0]  chk_q;
    logic [7:0]  chk_in;
    logic [7:0]  tx_byte;
    logic        txd_nxt, busy_nxt, done_nxt;
    logic        accept;

    assign accept = (state == IDLE) && start;
    assign chk_in = data[31:24] + data[23:16] + data[15:8] + data[7:0];

    // State register (outputs are registered alongside so txd is glitch-free)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            data_q   <= '0;
            chk_q    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            txd      <= txd_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (accept) begin
                data_q <= data;
                chk_q  <= chk_in;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                bit_nxt  = '0;
                byte_nxt = '0;
                if (start) state_nxt = START_BIT;
            end
            START_BIT: begin
                if (cnt == BIT_LAST) begin
                    state_nxt = DATA_BITS;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            DATA_BITS: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) state_nxt = STOP_BIT;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end
            end
            STOP_BIT: begin
                if (byte_idx == 3'd5) begin
                    if (cnt == END_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        byte_nxt  = '0;
                    end
                end else if (cnt == BIT_LAST) begin
                    state_nxt = START_BIT;
                    cnt_nxt   = '0;
                    byte_nxt  = byte_idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: registered outputs follow the next state
    always_comb begin
        case (byte_nxt)
            3'd0:    tx_byte = HEADER;
            3'd1:    tx_byte = data_q[31:24];
            3'd2:    tx_byte = data_q[23:16];
            3'd3:    tx_byte = data_q[15:8];
            3'd4:    tx_byte = data_q[7:0];
            default: tx_byte = chk_q;
        endcase
        case (state_nxt)
            START_BIT: txd_nxt = 1'b0;
            DATA_BITS: txd_nxt = tx_byte[bit_nxt];
            default:   txd_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP_BIT) && (state_nxt == IDLE);
    end

endmodule

// File: doc/freq_report_tx.md
FREQ_REPORT_TX -- requirements
Module: freq_report_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, is the number of clk cycles per UART bit (9600 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hAA, is the frame header byte.
REQ-003 Port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: request to send one frame; sampled every cycle.
REQ-006 Port data, input, 32: payload, typically freq_data_pool; captured only when start is accepted.
REQ-007 Port busy, output, 1: high while a frame is in flight.
REQ-008 Port done, output, 1: one-cycle pulse when a frame completes.
REQ-009 Port txd, output, 1: UART serial output; idle high; feeds the uart_mux tx input.

Function
REQ-010 The frame shall be 6 bytes in order: HEADER, data[31:24], data[23:16], data[15:8], data[7:0], CHK.
REQ-011 CHK shall be the sum of the four payload bytes truncated to 8 bits; carries are discarded.
REQ-012 Each byte shall be sent 8N1: start bit 0, data bits LSB first, stop bit 1, each bit held for exactly CLKS_PER_BIT cycles.
REQ-013 Consecutive bytes shall be back-to-back with no idle gap; a frame lasts exactly 60*CLKS_PER_BIT cycles.
REQ-014 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, with a byte index 0..5 and a bit index 0..7.
REQ-015 IDLE -> START_BIT when start=1 and busy=0; data shall be latched and CHK computed in that same cycle.
REQ-016 START_BIT -> DATA_BITS after CLKS_PER_BIT cycles.
REQ-017 DATA_BITS -> STOP_BIT after 8 bits.
REQ-018 STOP_BIT -> START_BIT (byte index +1) after CLKS_PER_BIT cycles when byte index < 5; otherwise -> IDLE.
REQ-019 txd shall be registered; if start is accepted in cycle N, txd shall be low from cycle N+1.
REQ-020 busy shall be high from cycle N+1 through the last stop-bit cycle.
REQ-021 On the final STOP_BIT -> IDLE transition, done shall be 1 for exactly one cycle and busy shall be 0 in that cycle.
REQ-022 start asserted while busy=1 shall be ignored entirely: not queued, and neither data nor CHK shall change.
REQ-023 start held high continuously shall send frames back-to-back: the cycle done=1 accepts the next frame, with one idle-high txd cycle between frames.
REQ-024 Changes on data after acceptance shall not affect the frame in flight.

Reset
REQ-025 While rst=1 (sampled on a clk edge): txd=1, busy=0, done=0, FSM=IDLE, all counters and indices zero; rst overrides start.
REQ-026 rst asserted mid-frame shall abort the frame; txd shall be 1 from the next cycle and no done pulse shall be produced.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-027 Basic frame: start pulse with data=32'h12345678 -> a UART monitor decodes AA 12 34 56 78 14; done occurs 240 cycles after start is sampled; busy is high for exactly 239 cycles.
REQ-028 Checksum wrap: data=32'hFFFFFFFF -> decoded AA FF FF FF FF FC.
REQ-029 Busy rejection: a second start with data=32'h00000001 at cycle 50 of a frame -> only one frame is sent, its payload is unchanged, and one done pulse occurs.
REQ-030 Data stability: data changes every cycle after acceptance -> the frame carries the payload sampled at the accept cycle.
REQ-031 Held start: start=1 for 500 cycles with data=32'h00000000 -> two complete frames AA 00 00 00 00 00, each followed by a done pulse, with txd=1 in the single gap cycle.
REQ-032 Mid-frame reset: rst for 1 cycle at cycle 100 -> txd=1 and busy=0 from the next cycle, no done pulse, and a subsequent start sends a correct full frame.
